ram_sdp_clr: RTL and testbench
==============================

Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, both on the same clock.
- Adds registered reads with selectable latency, read valid flag, write-first bypass and a hardware clear engine that initialises every word after reset or on request.
- Serves as the general storage primitive for data buffers and lookup tables in the datapath.

Parameters:
- DATA_W, 8, word width in bits (1..64)
- ADDR_W, 4, address width in bits (1..12)
- DEPTH, 16, number of words (2..2**ADDR_W)
- RD_LAT, 1, read latency in cycles (1 or 2 only)
- INIT_VAL, 0, DATA_W-bit value written by the clear engine

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  single-cycle request to re-run the clear engine
- busy  out  1  high while clearing; the ports are blocked
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_drop  out  1  one-cycle pulse when a write is discarded
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, held until the next valid read
- rd_valid  out  1  one-cycle pulse qualifying rd_data

Behaviour:
- Reset (rst_n=0 at an edge): state=CLEAR, clear pointer=0, busy=1, rd_data=0, rd_valid=0, wr_drop=0, all latency pipeline stages cleared. Memory contents are not reset directly.
- FSM states:
  - CLEAR: each edge with rst_n=1 writes INIT_VAL to mem[ptr] and increments ptr.
  - On the edge that writes ptr=DEPTH-1, go to IDLE; busy falls after that edge.
  - With rst_n held low then released, busy stays high for exactly DEPTH cycles.
  - IDLE: clr=1 moves the FSM to CLEAR with ptr=0; busy rises after that edge. Ports are still serviced on that same edge.
  - clr while already in CLEAR is ignored; the clear does not restart.
  - Reset mid-clear restarts the clear from ptr=0.
- Write:
  - In IDLE, wr_en=1 and wr_addr<DEPTH writes mem[wr_addr]<=wr_data on the edge.
  - wr_en=1 while busy, or with wr_addr>=DEPTH, discards the write and asserts wr_drop for one cycle after that edge.
- Read:
  - In IDLE, rd_en=1 samples rd_addr at edge N.
  - RD_LAT=1: rd_data/rd_valid are updated by edge N.
  - RD_LAT=2: they are updated by edge N+1.
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle (fully pipelined).
- Read while busy: dropped; rd_valid stays 0 and rd_data holds its value.
- Read with rd_addr>=DEPTH: accepted; returns INIT_VAL with rd_valid=1.
- Simultaneous write and read to the same address at the same edge: write-first. rd_data returns the new wr_data.
- Read at the edge after a write returns the written data; there is no hazard window.
- Pipeline stages already in flight when clr is accepted still complete and deliver rd_valid.
- Reset flushes the pipeline; no rd_valid is produced for reads issued before reset.

Test Plan:
- Reset and clear: hold rst_n=0 for 3 cycles, release → busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 then return 0x00 with rd_valid=1.
- Write/read, RD_LAT=1: write addr0..4 = 55, 99, 150, 200, 77 on consecutive cycles, then read addr0..4 back-to-back → rd_data 55, 99, 150, 200, 77 on 5 consecutive cycles, each one cycle after its rd_en, with rd_valid continuously high.
- Write-first bypass: addr3 holds 200; same edge wr_en=1, wr_addr=3, wr_data=0xA5, rd_en=1, rd_addr=3 → rd_data=0xA5 after that edge.
- Blocked while busy: pulse clr, next cycle wr_en=1 addr2 data 0x11 and rd_en=1 → wr_drop pulses, rd_valid=0. After busy falls, read addr2 → 0x00, not 0x11.
- Clear abort: INIT_VAL=0xFF, start clr, assert rst_n=0 at ptr=7, release → busy high for 16 full cycles, and all 16 addresses read 0xFF.
- RD_LAT=2 and DEPTH=12, ADDR_W=4:
  - rd_en at edge N → rd_valid after edge N+1.
  - Write to addr 13 → wr_drop=1, memory unchanged.
  - Read addr 13 → INIT_VAL, rd_valid=1.

Source files
------------

// File: rtl/ram_sdp_clr_if.sv
// Port bundle for ram_sdp_clr: clear control, write port and read port.
// The master drives requests; the slave (the RAM) returns status and read data.
interface ram_sdp_clr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              clr;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_drop;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, wr_drop, rd_data, rd_valid
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, wr_drop, rd_data, rd_valid
    );
endinterface

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with registered reads (latency 1 or 2), write-first
// bypass and a clear engine that fills every word with INIT_VAL after reset or on request.
module ram_sdp_clr #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    ram_sdp_clr_if.slave bus
);

    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              wr_ok;
    logic              rd_acc;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_drop_q;

    assign busy        = (state_q == StClear);
    assign wr_ok       = bus.wr_en && !busy && ({1'b0, bus.wr_addr} < DEPTH_V);
    assign rd_acc      = bus.rd_en && !busy;
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_V);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end
            end
            StIdle: begin
                if (bus.clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Single physical write port shared by the clear engine and the user write.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = ptr_q[IDX_W-1:0];
        mem_wdata = INIT_VAL;
        if (busy) begin
            mem_we = rst_n;
        end else if (wr_ok) begin
            mem_we    = 1'b1;
            mem_idx   = bus.wr_addr[IDX_W-1:0];
            mem_wdata = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Write-first: a same-edge write to the read address is forwarded.
    always_comb begin
        rd_word = mem[bus.rd_addr[IDX_W-1:0]];
        if (!rd_in_range) begin
            rd_word = INIT_VAL;
        end else if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
            rd_word = bus.wr_data;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s1_valid_q;
        logic [DATA_W-1:0] s1_data_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_acc;
                if (rd_acc) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign out_valid = s1_valid_q;
        assign out_data  = s1_data_q;
    end else begin : g_lat1
        assign out_valid = rd_acc;
        assign out_data  = rd_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_valid_q <= out_valid;
            if (out_valid) begin
                rd_data_q <= out_data;
            end
            wr_drop_q <= bus.wr_en && !wr_ok;
        end
    end

    assign bus.busy     = busy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: three configurations share one stimulus stream and are compared
// every cycle against a behavioural model, with directed checks for the key scenarios.
module tb_ram_sdp_clr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();
    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) bus2 ();

    assign bus0.clr = clr;         assign bus1.clr = clr;         assign bus2.clr = clr;
    assign bus0.wr_en = wr_en;     assign bus1.wr_en = wr_en;     assign bus2.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr; assign bus2.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
    assign bus0.rd_en = rd_en;     assign bus1.rd_en = rd_en;     assign bus2.rd_en = rd_en;
    assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr; assign bus2.rd_addr = rd_addr;

    ram_sdp_clr #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .INIT_VAL(8'h00)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    ram_sdp_clr #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .INIT_VAL(8'hFF)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    ram_sdp_clr #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .INIT_VAL(8'h3C)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    logic       obs_busy [3];
    logic       obs_drop [3];
    logic       obs_rv   [3];
    logic [7:0] obs_rd   [3];

    assign obs_busy[0] = bus0.busy;    assign obs_busy[1] = bus1.busy;    assign obs_busy[2] = bus2.busy;
    assign obs_drop[0] = bus0.wr_drop; assign obs_drop[1] = bus1.wr_drop; assign obs_drop[2] = bus2.wr_drop;
    assign obs_rv[0] = bus0.rd_valid;  assign obs_rv[1] = bus1.rd_valid;  assign obs_rv[2] = bus2.rd_valid;
    assign obs_rd[0] = bus0.rd_data;   assign obs_rd[1] = bus1.rd_data;   assign obs_rd[2] = bus2.rd_data;

    // Reference model: per-instance memory image, clear countdown and read delay line.
    int         m_depth [3] = '{16, 16, 12};
    int         m_lat   [3] = '{1, 1, 2};
    logic [7:0] m_init  [3] = '{8'h00, 8'hFF, 8'h3C};
    logic [7:0] m_mem   [3][16];
    int         m_clear [3];
    logic       m_s1v   [3];
    logic [7:0] m_s1d   [3];
    logic       m_rv    [3];
    logic [7:0] m_rd    [3];
    logic       m_drop  [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_clear[k] = m_depth[k];
                m_s1v[k]   = 1'b0;
                m_s1d[k]   = 8'h00;
                m_rv[k]    = 1'b0;
                m_rd[k]    = 8'h00;
                m_drop[k]  = 1'b0;
            end else begin
                logic       busy_now;
                logic       wok;
                logic       nv;
                logic [7:0] nd;
                busy_now  = (m_clear[k] > 0);
                wok       = wr_en && !busy_now && (int'(wr_addr) < m_depth[k]);
                m_drop[k] = wr_en && !wok;
                if (wok) m_mem[k][wr_addr] = wr_data;
                nv = rd_en && !busy_now;
                nd = (int'(rd_addr) >= m_depth[k]) ? m_init[k] : m_mem[k][rd_addr];
                if (m_lat[k] == 1) begin
                    m_rv[k] = nv;
                    if (nv) m_rd[k] = nd;
                end else begin
                    m_rv[k] = m_s1v[k];
                    if (m_s1v[k]) m_rd[k] = m_s1d[k];
                    m_s1v[k] = nv;
                    if (nv) m_s1d[k] = nd;
                end
                if (busy_now) begin
                    m_clear[k]--;
                    if (m_clear[k] == 0) begin
                        for (int i = 0; i < m_depth[k]; i++) m_mem[k][i] = m_init[k];
                    end
                end else if (clr) begin
                    m_clear[k] = m_depth[k];
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k), {7'd0, obs_busy[k]}, {7'd0, m_clear[k] > 0});
            chk($sformatf("wr_drop%0d", k), {7'd0, obs_drop[k]}, {7'd0, m_drop[k]});
            chk($sformatf("rd_valid%0d", k), {7'd0, obs_rv[k]}, {7'd0, m_rv[k]});
            chk($sformatf("rd_data%0d", k), obs_rd[k], m_rd[k]);
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    initial begin
        logic [7:0] vals [5];
        int         n;
        vals = '{8'd55, 8'd99, 8'd150, 8'd200, 8'd77};

        // Reset for three cycles, then the clear runs for exactly DEPTH cycles.
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        chk("rst_busy", {7'd0, obs_busy[0]}, 8'd1);
        chk("rst_rd_data", obs_rd[0], 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("clr_len", {7'd0, obs_busy[0]}, {7'd0, i < 15});
        end

        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            tick();
        end
        idle_inputs();
        repeat (2) tick();

        // Write five words, then read them back-to-back.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = vals[i];
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            tick();
            chk("b2b_data", obs_rd[0], vals[i]);
            chk("b2b_valid", {7'd0, obs_rv[0]}, 8'd1);
        end
        idle_inputs();
        repeat (2) tick();

        // Same-edge write and read to one address.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        chk("bypass", obs_rd[0], 8'hA5);
        idle_inputs();
        repeat (2) tick();

        // Requests are blocked while the clear engine runs.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        chk("blk_drop", {7'd0, obs_drop[0]}, 8'd1);
        chk("blk_valid", {7'd0, obs_rv[0]}, 8'd0);
        idle_inputs();
        n = 0;
        while (obs_busy[0] && n < 40) begin
            tick();
            n++;
        end
        chk("busy_fall", {7'd0, obs_busy[0]}, 8'd0);
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        chk("blk_after", obs_rd[0], 8'h00);
        idle_inputs();
        repeat (2) tick();

        // Reset in the middle of a clear restarts it from the first word.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("abort_len", {7'd0, obs_busy[1]}, {7'd0, i < 15});
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            tick();
            chk("abort_data", obs_rd[1], 8'hFF);
        end
        idle_inputs();
        repeat (2) tick();

        // Out-of-range write and read on the 12-word, two-cycle-latency instance.
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h5A;
        tick();
        chk("oor_drop", {7'd0, obs_drop[2]}, 8'd1);
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd13;
        tick();
        chk("lat2_n", {7'd0, obs_rv[2]}, 8'd0);
        idle_inputs();
        tick();
        chk("lat2_n1", {7'd0, obs_rv[2]}, 8'd1);
        chk("oor_data", obs_rd[2], 8'h3C);
        tick();
        chk("lat2_pulse", {7'd0, obs_rv[2]}, 8'd0);

        // Random traffic with occasional clear requests and resets.
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            clr     = ($urandom_range(0, 39) == 0);
            wr_en   = 1'($urandom);
            wr_addr = 4'($urandom);
            wr_data = 8'($urandom);
            rd_en   = 1'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
